fifo_umbral: RTL and testbench

Single-clock FIFO with programmable almost-full/almost-empty thresholds (umbrales) and sticky overflow/underflow error. It is the storage end of the link-control state machine's interface: it consumes the threshold values that the control FSM distributes, and produces the per-FIFO `empty`/`error` bits that the FSM gathers into `FIFO_empties`/`FIFO_errors`. Five instances, one per FIFO, make up the transmit buffer bank.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/mem_dual_port.sv | 34 +++
 rtl/fifo_umbral.sv | 114 +++++++++++
 tb/tb_fifo_umbral.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the transmit FIFO bank: default widths, depth
// derivation, bank size and the request encoding used by the count update.
package fifo_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 3;
  localparam int U_W_DEF    = 4;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  // Width of the FIFO_empties / FIFO_errors vectors gathered by the control FSM.
  localparam int N_FIFOS = 5;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_RD   = 2'b01,
    REQ_WR   = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/mem_dual_port.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered,
// enable-gated read port. No reset: contents and read register are data only.
module mem_dual_port
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a simultaneous write to raddr returns the old word.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and
// a sticky overflow/underflow error flag. Flags are registered from count_d.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int U_W    = U_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [U_W-1:0]    umbral_alto,
  input  logic [U_W-1:0]    umbral_bajo,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, error_q, error_d;
  logic              empty_q, full_q, afull_q, aempty_q;
  logic              dout_zero_q;
  logic              rd_ok, wr_ok, overflow, underflow;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;
  req_e              req;

  assign rd_ok     = pop && (count_q != '0);
  assign wr_ok     = push && ((count_q != CNT_DEPTH) || rd_ok);
  assign overflow  = push && (count_q == CNT_DEPTH) && !rd_ok;
  assign underflow = pop && (count_q == '0);
  assign req       = req_e'({wr_ok, rd_ok});

  // Requests presented during the reset cycle must not touch storage.
  assign mem_we = wr_ok && reset;
  assign mem_re = rd_ok && reset;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    error_d  = error_q || overflow || underflow;
    unique case (req)
      REQ_WR:   count_d = count_q + CNT_ONE;
      REQ_RD:   count_d = count_q - CNT_ONE;
      default:  count_d = count_q;
    endcase
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      dout_zero_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= rd_ok;
      error_q  <= error_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_DEPTH);
      afull_q  <= (U_W'(count_d) >= umbral_alto);
      aempty_q <= (U_W'(count_d) <= umbral_bajo);
      if (rd_ok) dout_zero_q <= 1'b0;
    end
  end

  mem_dual_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // The read register has no reset, so data_out reads as zero until the first pop.
  assign data_out     = dout_zero_q ? '0 : mem_rdata;
  assign valid_out    = valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: fill/drain, overflow/underflow, wrap with
// simultaneous push/pop, threshold change and mid-operation reset.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [9:0] data_in = '0;
  logic       pop = 1'b0;
  logic [3:0] umbral_alto = 4'd6;
  logic [3:0] umbral_bajo = 4'd2;
  logic [9:0] data_out;
  logic       valid_out, empty, full, almost_full, almost_empty, error;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, " full"}, 32'(full), 32'd0);
    check({tag, " almost_full"}, 32'(almost_full), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " valid_out"}, 32'(valid_out), 32'd0);
    check({tag, " data_out"}, 32'(data_out), 32'd0);
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset with requests asserted: they must be ignored.
    push = 1'b1; pop = 1'b1; data_in = 10'h3FF; reset = 1'b0;
    step(); step();
    push = 1'b0; pop = 1'b0; reset = 1'b1;
    step();
    check_reset_state("rst");

    // Fill 1..8 with alto=6, bajo=2.
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; data_in = 10'(i);
      step();
      check($sformatf("fill%0d aempty", i), 32'(almost_empty), 32'(i <= 2));
      check($sformatf("fill%0d afull", i), 32'(almost_full), 32'(i >= 6));
      check($sformatf("fill%0d full", i), 32'(full), 32'(i == 8));
      check($sformatf("fill%0d empty", i), 32'(empty), 32'd0);
    end
    check("no err before ovf", 32'(error), 32'd0);
    data_in = 10'h009;
    step();
    push = 1'b0;
    check("ovf error", 32'(error), 32'd1);
    check("ovf full", 32'(full), 32'd1);

    // Drain 8 in order.
    for (int i = 1; i <= 8; i++) begin
      pop = 1'b1;
      step();
      check($sformatf("drain%0d data", i), 32'(data_out), 32'(i));
      check($sformatf("drain%0d valid", i), 32'(valid_out), 32'd1);
      check($sformatf("drain%0d empty", i), 32'(empty), 32'(i == 8));
      check($sformatf("drain%0d full", i), 32'(full), 32'd0);
    end
    step();
    pop = 1'b0;
    check("unf valid", 32'(valid_out), 32'd0);
    check("unf error", 32'(error), 32'd1);
    check("unf data held", 32'(data_out), 32'd8);

    // Push+pop on empty: push kept, pop is an underflow.
    push = 1'b1; pop = 1'b1; data_in = 10'h155;
    step();
    push = 1'b0;
    check("pp_empty error", 32'(error), 32'd1);
    check("pp_empty valid", 32'(valid_out), 32'd0);
    check("pp_empty empty", 32'(empty), 32'd0);
    check("pp_empty aempty", 32'(almost_empty), 32'd1);
    step();
    pop = 1'b0;
    check("pp_empty data", 32'(data_out), 32'h155);
    check("pp_empty valid2", 32'(valid_out), 32'd1);
    check("pp_empty empty2", 32'(empty), 32'd1);

    // Clear error, offset pointers by 3, then fill so both pointers wrap.
    do_reset();
    step();
    check_reset_state("rst2");
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; data_in = 10'h0F0 + 10'(i);
      step();
    end
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      step();
      check($sformatf("pre%0d data", i), 32'(data_out), 32'h0F0 + 32'(i));
    end
    pop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; data_in = 10'h100 + 10'(i);
      step();
    end
    check("wrap full", 32'(full), 32'd1);
    pop = 1'b1; data_in = 10'h2AA;
    step();
    push = 1'b0;
    check("pp_full error", 32'(error), 32'd0);
    check("pp_full full", 32'(full), 32'd1);
    check("pp_full data", 32'(data_out), 32'h100);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("wdrain%0d data", i), 32'(data_out), (i == 8) ? 32'h2AA : 32'h100 + 32'(i));
    end
    pop = 1'b0;
    check("wdrain empty", 32'(empty), 32'd1);
    check("wdrain error", 32'(error), 32'd0);

    // Fill to 5, lower alto from 6 to 4, then reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; data_in = 10'h050 + 10'(i);
      step();
    end
    push = 1'b0;
    check("five afull@6", 32'(almost_full), 32'd0);
    umbral_alto = 4'd4;
    step();
    check("five afull@4", 32'(almost_full), 32'd1);
    check("five aempty", 32'(almost_empty), 32'd0);
    push = 1'b1; data_in = 10'h3FF; pop = 1'b1; reset = 1'b0;
    step();
    push = 1'b0; pop = 1'b0; reset = 1'b1;
    check_reset_state("rst3");
    step();
    check("post-rst empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
